// File: rtl/fp32_mul_arbiter.sv
// Round-robin share of one pipelined fp32_mul between N_REQ requesters; results routed back by tag.
// Latency MUL_LATENCY+2 from handshake to response; requests stall via req_ready_out, responses cannot stall.
module fp32_mul_arbiter #(
   parameter int N_REQ       = 4,
   parameter int MUL_LATENCY = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [N_REQ-1:0]       req_valid_in,
   input  logic [N_REQ-1:0][31:0] req_a_in,
   input  logic [N_REQ-1:0][31:0] req_b_in,
   output logic [N_REQ-1:0]       req_ready_out,
   output logic                   mul_valid_out,
   output logic [31:0]            mul_a_out,
   output logic [31:0]            mul_b_out,
   input  logic                   mul_valid_in,
   input  logic [31:0]            mul_c_in,
   output logic [N_REQ-1:0]       resp_valid_out,
   output logic [31:0]            resp_c_out,
   output logic                   err_out
);
   localparam int TAG_W = $clog2(N_REQ);
   localparam int SUM_W = TAG_W + 1;

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
   } tag_ent_t;

   logic [TAG_W-1:0] ptr;
   logic [TAG_W-1:0] grant_idx;
   logic             grant_vld;
   logic [SUM_W-1:0] cand;
   tag_ent_t         issue_ent;
   tag_ent_t         pipe [MUL_LATENCY];
   tag_ent_t         tag_out;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = SUM_W'(ptr) + SUM_W'(k);
         if (cand >= SUM_W'(N_REQ)) cand = cand - SUM_W'(N_REQ);
         if (!grant_vld && req_valid_in[cand[TAG_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[TAG_W-1:0];
         end
      end
      if (rst_in) grant_vld = 1'b0;
   end

   assign req_ready_out = grant_vld ? (N_REQ'(1) << grant_idx) : '0;
   assign tag_out       = pipe[MUL_LATENCY-1];

   // issue_ent rides alongside the issue register, so the MUL_LATENCY-deep pipe
   // behind it lines up with the multiplier's own depth behind mul_valid_out.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ptr            <= '0;
         mul_valid_out  <= 1'b0;
         mul_a_out      <= '0;
         mul_b_out      <= '0;
         issue_ent      <= '0;
         for (int s = 0; s < MUL_LATENCY; s++) pipe[s] <= '0;
         resp_valid_out <= '0;
         resp_c_out     <= '0;
         err_out        <= 1'b0;
      end else begin
         mul_valid_out <= grant_vld;
         issue_ent     <= '{vld: grant_vld, tag: grant_idx};
         if (grant_vld) begin
            ptr       <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
            mul_a_out <= req_a_in[grant_idx];
            mul_b_out <= req_b_in[grant_idx];
         end
         pipe[0] <= issue_ent;
         for (int s = 1; s < MUL_LATENCY; s++) pipe[s] <= pipe[s-1];
         resp_valid_out <= mul_valid_in ? (N_REQ'(1) << tag_out.tag) : '0;
         if (mul_valid_in) resp_c_out <= mul_c_in;
         if (mul_valid_in != tag_out.vld) err_out <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Directed bench for fp32_mul_arbiter with a stub multiplier and a response scoreboard.
module tb_fp32_mul_arbiter;
   localparam int N = 4;
   localparam int L = 4;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b1;
   logic [N-1:0]      req_valid_in = '0;
   logic [N-1:0][31:0] req_a_in;
   logic [N-1:0][31:0] req_b_in;
   logic [N-1:0]      req_ready_out;
   logic              mul_valid_out;
   logic [31:0]       mul_a_out, mul_b_out;
   logic              mul_valid_in;
   logic [31:0]       mul_c_in;
   logic [N-1:0]      resp_valid_out;
   logic [31:0]       resp_c_out;
   logic              err_out;

   fp32_mul_arbiter #(.N_REQ(N), .MUL_LATENCY(L)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_valid_in(req_valid_in), .req_a_in(req_a_in), .req_b_in(req_b_in),
      .req_ready_out(req_ready_out),
      .mul_valid_out(mul_valid_out), .mul_a_out(mul_a_out), .mul_b_out(mul_b_out),
      .mul_valid_in(mul_valid_in), .mul_c_in(mul_c_in),
      .resp_valid_out(resp_valid_out), .resp_c_out(resp_c_out), .err_out(err_out)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0, errors = 0, cyc = 0, resp_cnt = 0;
   bit sb_off = 1'b0;
   logic stub_vld = 1'b0;
   logic [31:0] stub_c = 32'hDEADBEEF;

   typedef struct {
      logic [N-1:0] mask;
      logic [31:0]  c;
      int           cyc;
   } exp_t;
   exp_t sb_q[$];
   int   grant_q[$];

   // Known products from the reference vectors; anything else gets a cheap stand-in.
   function automatic logic [31:0] exp_c(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         64'h43970FFD_40C91759: return 32'h44ED52A9;
         64'h3DFFCB92_3FA45D64: return 32'h3E243BBA;
         64'hC141BE77_40E6C99B: return 32'hC2AEA9B3;
         64'h3DE31F8A_BDD53261: return 32'hBC3D25F0;
         default:               return a ^ b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Stub multiplier: L-deep pipe, shares rst_in with the DUT.
   logic [L-1:0] mv;
   logic [31:0]  mc [L];
   always @(posedge clk_in) begin
      if (rst_in) mv <= '0;
      else begin
         mv    <= {mv[L-2:0], mul_valid_out};
         mc[0] <= exp_c(mul_a_out, mul_b_out);
         for (int i = 1; i < L; i++) mc[i] <= mc[i-1];
      end
   end
   assign mul_valid_in = mv[L-1] | stub_vld;
   assign mul_c_in     = mv[L-1] ? mc[L-1] : stub_c;

   always @(posedge clk_in) cyc <= cyc + 1;

   exp_t e;
   always @(negedge clk_in) begin
      if (resp_valid_out != '0 && !sb_off) begin
         resp_cnt++;
         if (sb_q.size() == 0) chk("resp_unexpected", 32'(resp_valid_out), 32'h0);
         else begin
            e = sb_q.pop_front();
            chk("resp_mask", 32'(resp_valid_out), 32'(e.mask));
            chk("resp_c", resp_c_out, e.c);
            chk("resp_latency", cyc - e.cyc, L + 2);
         end
      end
      if (rst_in) sb_q.delete();
      for (int i = 0; i < N; i++) begin
         if (req_valid_in[i] && req_ready_out[i]) begin
            sb_q.push_back('{mask: N'(1) << i, c: exp_c(req_a_in[i], req_b_in[i]), cyc: cyc});
            grant_q.push_back(i);
         end
      end
   end

   task automatic issue(input logic [N-1:0] mask);
      logic [N-1:0] acc;
      int budget = 0;
      @(posedge clk_in); #1;
      req_valid_in = mask;
      while (req_valid_in != '0 && budget < 20) begin
         @(negedge clk_in);
         acc = req_valid_in & req_ready_out;
         @(posedge clk_in); #1;
         req_valid_in = req_valid_in & ~acc;
         budget++;
      end
      chk("issue_accepted", 32'(req_valid_in), 32'h0);
      req_valid_in = '0;
   endtask

   task automatic do_reset();
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      req_valid_in = '0;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      grant_q.delete();
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk_in);
         n++;
      end
      repeat (3) @(negedge clk_in);
      chk("drain", sb_q.size(), 0);
   endtask

   task automatic check_grant(input string tag, input int exp);
      int got;
      got = (grant_q.size() > 0) ? grant_q.pop_front() : -1;
      chk(tag, got, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   int r0;
   initial begin
      req_a_in = '0;
      req_b_in = '0;
      req_valid_in = '1;
      @(negedge clk_in);
      chk("rst_ready", 32'(req_ready_out), 32'h0);
      @(posedge clk_in);
      @(negedge clk_in);
      chk("rst_mul_vld", 32'(mul_valid_out), 32'h0);
      chk("rst_mul_a", mul_a_out, 32'h0);
      chk("rst_mul_b", mul_b_out, 32'h0);
      chk("rst_resp_vld", 32'(resp_valid_out), 32'h0);
      chk("rst_resp_c", resp_c_out, 32'h0);
      chk("rst_err", 32'(err_out), 32'h0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      req_valid_in = '0;
      grant_q.delete();

      // Single request
      req_a_in[0] = 32'h43970FFD;
      req_b_in[0] = 32'h40C91759;
      @(posedge clk_in); #1;
      req_valid_in = 4'b0001;
      @(negedge clk_in);
      chk("single_ready", 32'(req_ready_out), 32'h1);
      @(posedge clk_in); #1;
      req_valid_in = '0;
      @(negedge clk_in);
      chk("single_mul_vld", 32'(mul_valid_out), 32'h1);
      chk("single_mul_a", mul_a_out, 32'h43970FFD);
      chk("single_mul_b", mul_b_out, 32'h40C91759);
      @(negedge clk_in);
      chk("single_mul_vld_off", 32'(mul_valid_out), 32'h0);
      chk("single_mul_a_hold", mul_a_out, 32'h43970FFD);
      wait_drain();
      chk("single_resp_cnt", resp_cnt, 1);
      chk("single_err", 32'(err_out), 32'h0);

      // All four requesting from reset
      do_reset();
      req_a_in[1] = 32'h3DFFCB92; req_b_in[1] = 32'h3FA45D64;
      req_a_in[2] = 32'hC141BE77; req_b_in[2] = 32'h40E6C99B;
      req_a_in[3] = 32'h3DE31F8A; req_b_in[3] = 32'hBDD53261;
      issue(4'b1111);
      for (int k = 0; k < 4; k++) check_grant("all4_grant", k);
      wait_drain();
      chk("all4_resp_cnt", resp_cnt, 5);

      // Fairness between 0 and 2
      do_reset();
      req_a_in[0] = 32'h3F800000; req_b_in[0] = 32'h40000000;
      req_a_in[2] = 32'h40400000; req_b_in[2] = 32'h40800000;
      @(posedge clk_in); #1;
      req_valid_in = 4'b0101;
      repeat (8) @(posedge clk_in);
      #1;
      req_valid_in = '0;
      chk("fair_count", grant_q.size(), 8);
      for (int k = 0; k < 8; k++) check_grant("fair_grant", (k % 2 == 0) ? 0 : 2);
      wait_drain();

      // Pointer wrap
      do_reset();
      req_a_in[3] = 32'h12345678; req_b_in[3] = 32'h0F0F0F0F;
      issue(4'b1000);
      issue(4'b1001);
      check_grant("wrap_first", 3);
      check_grant("wrap_second", 0);
      check_grant("wrap_third", 3);
      wait_drain();

      // Reset while three operations are in flight
      do_reset();
      r0 = resp_cnt;
      issue(4'b0111);
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("midrst_mul_vld", 32'(mul_valid_out), 32'h0);
      chk("midrst_mul_a", mul_a_out, 32'h0);
      chk("midrst_resp_vld", 32'(resp_valid_out), 32'h0);
      chk("midrst_resp_c", resp_c_out, 32'h0);
      chk("midrst_err", 32'(err_out), 32'h0);
      repeat (12) @(negedge clk_in);
      chk("midrst_no_resp", resp_cnt, r0);
      req_a_in[1] = 32'hA5A5A5A5; req_b_in[1] = 32'h0000FFFF;
      issue(4'b0010);
      wait_drain();
      chk("midrst_next_op", resp_cnt, r0 + 1);
      chk("midrst_err_after", 32'(err_out), 32'h0);

      // Stray mul_valid_in with an empty tag pipe
      sb_off = 1'b1;
      do_reset();
      @(negedge clk_in);
      chk("err_clear_before", 32'(err_out), 32'h0);
      @(posedge clk_in); #1;
      stub_vld = 1'b1;
      @(posedge clk_in); #1;
      stub_vld = 1'b0;
      @(negedge clk_in);
      chk("err_set", 32'(err_out), 32'h1);
      repeat (5) @(negedge clk_in);
      chk("err_sticky", 32'(err_out), 32'h1);
      do_reset();
      @(negedge clk_in);
      chk("err_cleared_by_rst", 32'(err_out), 32'h0);
      sb_off = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp32_mul_arbiter.md
# fp32_mul_arbiter

Shares one pipelined `fp32_mul` between `N_REQ` requesters using round-robin arbitration, at most one issue per cycle. Each issued operation carries a requester tag through a shift pipe matched to the multiplier latency. Each result is returned only to the requester that issued it. The block sits between the shading/transform stages and the single multiplier instance, so several consumers can use the unit without duplicating it.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `MUL_LATENCY`, default 4: cycles from `fp32_mul` `valid_in` to `valid_out`. Must equal the instantiated multiplier's pipeline depth.

Ports:
- `clk_in`  input  1  system clock; all logic on the rising edge.
- `rst_in`  input  1  synchronous, active-high reset.
- `req_valid_in`  input  N_REQ  per-requester operation valid.
- `req_a_in`  input  N_REQ×32  per-requester operand A, IEEE-754 single.
- `req_b_in`  input  N_REQ×32  per-requester operand B.
- `req_ready_out`  output  N_REQ  one-hot or zero; the request is accepted this cycle.
- `mul_valid_out`  output  1  to `fp32_mul.valid_in`.
- `mul_a_out`  output  32  to `fp32_mul.a_in`.
- `mul_b_out`  output  32  to `fp32_mul.b_in`.
- `mul_valid_in`  input  1  from `fp32_mul.valid_out`.
- `mul_c_in`  input  32  from `fp32_mul.c_out`.
- `resp_valid_out`  output  N_REQ  one-hot or zero result strobe.
- `resp_c_out`  output  32  result, shared by all requesters, qualified by `resp_valid_out`.
- `err_out`  output  1  sticky tag/valid mismatch flag.

## Operation

- **Handshake.**
  - A transfer on requester i happens in a cycle where `req_valid_in[i]` and `req_ready_out[i]` are both high.
  - `req_ready_out` is combinational from `req_valid_in` and the priority pointer.
  - A requester must hold its operands stable and keep valid high until accepted.
  - There is no response backpressure: the requester must accept `resp_valid_out` in the cycle it is asserted.
- **Arbitration.**
  - The search starts at `ptr`, covers indices `ptr, ptr+1, … ptr+N_REQ-1` mod N_REQ, and grants the first valid index.
  - On a grant to index g, `ptr` ← (g+1) mod N_REQ.
  - With no valid requests, `ptr` is held.
  - `ptr` resets to 0.
- **Issue register.**
  - On a grant, the next cycle drives `mul_valid_out`=1 with the granted `a`/`b`.
  - With no grant, the next cycle drives `mul_valid_out`=0 and `mul_a_out`/`mul_b_out` hold their previous values.
- **Tag pipe.**
  - A `MUL_LATENCY`-stage shift register of {valid, tag[$clog2(N_REQ)-1:0]}.
  - It is loaded in parallel with the issue register and shifts every cycle.
  - Its output stage is aligned with `mul_valid_in`.
- **Response register.**
  - Each cycle: `resp_valid_out` ← `mul_valid_in` ? onehot(tag_out) : 0.
  - `resp_c_out` ← `mul_c_in` when `mul_valid_in`=1, otherwise it holds.
- **Error.**
  - `err_out` is set when `mul_valid_in` ≠ tag-pipe output valid.
  - It stays set until reset.
  - A mismatching `mul_valid_in` still produces a response, routed by `tag_out` (garbage tolerated).
- **Reset values:**
  - `req_ready_out`=0 while `rst_in` is high.
  - `mul_valid_out`=0, `mul_a_out`=0, `mul_b_out`=0.
  - All tag-pipe valid bits 0.
  - `resp_valid_out`=0, `resp_c_out`=0, `err_out`=0, `ptr`=0.

## Timing

- Throughput: one operation per cycle across all requesters. One requester alone can issue every cycle.
- Latency from an accepted handshake at edge t:
  - `mul_valid_out` at t+1.
  - `mul_valid_in` at t+1+MUL_LATENCY.
  - `resp_valid_out` at t+2+MUL_LATENCY, i.e. MUL_LATENCY+2 cycles; 6 with the default.
- Results return in issue order.
- Simultaneous requests: exactly one grant per cycle. Losers keep valid asserted and, under contention, are each granted within N_REQ cycles.
- **Reset mid-operation.** The tag pipe and all outputs clear in the reset cycle and in-flight operations are discarded. `fp32_mul` shares `rst_in`, so no stale `mul_valid_in` is expected; one arriving after reset sets `err_out`.
- Pointer wrap: a grant to N_REQ-1 sets `ptr`=0.

## Test plan

- **Single request.**
  - Stimulus: requester 0 issues a=0x43970FFD, b=0x40C91759.
  - Required response: `req_ready_out`=4'b0001 the same cycle; `mul_valid_out` one cycle later; `resp_valid_out`=4'b0001 with `resp_c_out`=0x44ED52A9 exactly MUL_LATENCY+2 cycles after the handshake; `err_out`=0.
- **All four requesting.**
  - Stimulus: all four requesters assert valid in the same cycle from reset:
    - req0: 0x43970FFD×0x40C91759
    - req1: 0x3DFFCB92×0x3FA45D64
    - req2: 0xC141BE77×0x40E6C99B
    - req3: 0x3DE31F8A×0xBDD53261
  - Required response: grants in order 0,1,2,3 on consecutive cycles; responses on consecutive cycles: 0001/0x44ED52A9, 0010/0x3E243BBA, 0100/0xC2AEA9B3, 1000/0xBC3D25F0.
- **Fairness.**
  - Stimulus: requesters 0 and 2 hold valid continuously for 8 cycles.
  - Required response: grants alternate 0,2,0,2…; neither requester is granted twice in a row.
- **Pointer wrap.**
  - Stimulus: only requester 3 requests, then requesters 0 and 3 request together.
  - Required response: the second grant goes to 0 (`ptr` wrapped to 0).
- **Reset mid-flight.**
  - Stimulus: issue 3 operations, then assert `rst_in` for 1 cycle while they are in flight.
  - Required response: no `resp_valid_out` for any of them; all outputs at reset values; `err_out`=0; the next operation completes normally.
- **Error detection.**
  - Stimulus: drive `mul_valid_in`=1 from a stub multiplier with the tag pipe empty.
  - Required response: `err_out`=1 the next cycle and it stays set until `rst_in`.
